// File: rtl/cell_draw_scheduler_if.sv
// Pixel-scheduler bus: cell erase/draw requests in, one x/y/colour/wren pixel stream out.
// Optional clear handshake present when CELL_DRAW_CLEAR_EN is defined.
interface cell_draw_scheduler_if;
    logic       erase_req;
    logic [7:0] erase_x;
    logic [6:0] erase_y;
    logic       erase_ack;
    logic       draw_req;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_colour;
    logic       draw_ack;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       wren;
`ifdef CELL_DRAW_CLEAR_EN
    logic       clear_req;
    logic       clear_ack;
`endif

    modport master (
        output erase_req, erase_x, erase_y, draw_req, draw_x, draw_y, draw_colour,
`ifdef CELL_DRAW_CLEAR_EN
        output clear_req,
        input  clear_ack,
`endif
        input  erase_ack, draw_ack, busy, done, x, y, colour, wren
    );

    modport slave (
        input  erase_req, erase_x, erase_y, draw_req, draw_x, draw_y, draw_colour,
`ifdef CELL_DRAW_CLEAR_EN
        input  clear_req,
        output clear_ack,
`endif
        output erase_ack, draw_ack, busy, done, x, y, colour, wren
    );
endinterface

// File: rtl/cell_draw_scheduler.sv
// Expands cell erase/draw requests into CELL x CELL pixel writes, erase ordered before draw.
// Define CELL_DRAW_CLEAR_EN to add a full-screen black clear request (CLEAR state).
module cell_draw_scheduler #(
    parameter int CELL      = 4,
    parameter int CELL_LOG2 = 2,
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120
) (
    input  logic                 clk,
    input  logic                 resetn,
    cell_draw_scheduler_if.slave bus
);

    localparam int CW = (CELL_LOG2 == 0) ? 1 : 2 * CELL_LOG2;
    localparam logic [CW-1:0] LAST = CW'(CELL * CELL - 1);

`ifdef CELL_DRAW_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE, S_CLEAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;
`endif

    state_t        r_state, w_nx_state;
    logic [CW-1:0] r_cnt, w_nx_cnt;
    logic [7:0]    r_bx, w_nx_bx;
    logic [6:0]    r_by, w_nx_by;
    logic [2:0]    r_bcol, w_nx_bcol;
    logic          r_from_erase, w_nx_from_erase;
    logic [7:0]    r_x, w_nx_x;
    logic [6:0]    r_y, w_nx_y;
    logic [2:0]    r_col, w_nx_col;
    logic          r_wren, w_nx_wren;
    logic          r_eack, w_nx_eack;
    logic          r_dack, w_nx_dack;
    logic          r_done, w_nx_done;
    logic          r_busy;
    logic          w_take_draw;
    logic [7:0]    w_px_x;
    logic [6:0]    w_px_y;
    logic          w_on_screen;
`ifdef CELL_DRAW_CLEAR_EN
    logic          r_cack, w_nx_cack;
`endif

    // Counter low bits are the column, high bits the row (row-major within a cell).
    assign w_px_x      = r_bx + 8'(int'(r_cnt) & (CELL - 1));
    assign w_px_y      = r_by + 7'(int'(r_cnt) >> CELL_LOG2);
    assign w_on_screen = ({1'b0, w_px_x} < 9'(SCR_W)) && ({1'b0, w_px_y} < 8'(SCR_H));

    always_comb begin
        w_nx_state      = r_state;
        w_nx_cnt        = r_cnt;
        w_nx_bx         = r_bx;
        w_nx_by         = r_by;
        w_nx_bcol       = r_bcol;
        w_nx_from_erase = r_from_erase;
        w_nx_x          = r_x;
        w_nx_y          = r_y;
        w_nx_col        = r_col;
        w_nx_wren       = 1'b0;
        w_nx_eack       = 1'b0;
        w_nx_dack       = 1'b0;
        w_nx_done       = 1'b0;
        w_take_draw     = 1'b0;
`ifdef CELL_DRAW_CLEAR_EN
        w_nx_cack       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef CELL_DRAW_CLEAR_EN
                if (bus.clear_req) begin
                    w_nx_cack       = 1'b1;
                    w_nx_bx         = '0;
                    w_nx_by         = '0;
                    w_nx_from_erase = 1'b0;
                    w_nx_state      = S_CLEAR;
                end else
`endif
                if (bus.erase_req) begin
                    w_nx_eack       = 1'b1;
                    w_nx_bx         = bus.erase_x;
                    w_nx_by         = bus.erase_y;
                    w_nx_bcol       = '0;
                    w_nx_cnt        = '0;
                    w_nx_from_erase = 1'b1;
                    w_nx_state      = S_ERASE;
                end else if (bus.draw_req) begin
                    w_take_draw = 1'b1;
                end
            end
            S_ERASE, S_DRAW: begin
                w_nx_x    = w_px_x;
                w_nx_y    = w_px_y;
                w_nx_col  = r_bcol;
                w_nx_wren = w_on_screen;
                w_nx_cnt  = r_cnt + CW'(1);
                if (r_cnt == LAST) w_nx_state = S_DONE;
            end
            S_DONE: begin
                w_nx_done = 1'b1;
                // A draw pending behind an erase is taken here so the head overwrites the old tail.
                if (r_from_erase && bus.draw_req) begin
                    w_take_draw = 1'b1;
                end else begin
                    w_nx_from_erase = 1'b0;
                    w_nx_state      = S_IDLE;
                end
            end
`ifdef CELL_DRAW_CLEAR_EN
            S_CLEAR: begin
                w_nx_x    = r_bx;
                w_nx_y    = r_by;
                w_nx_col  = '0;
                w_nx_wren = 1'b1;
                if (r_bx == 8'(SCR_W - 1)) begin
                    w_nx_bx = '0;
                    if (r_by == 7'(SCR_H - 1)) w_nx_state = S_DONE;
                    else                       w_nx_by    = r_by + 7'd1;
                end else begin
                    w_nx_bx = r_bx + 8'd1;
                end
            end
`endif
            default: w_nx_state = S_IDLE;
        endcase
        if (w_take_draw) begin
            w_nx_dack       = 1'b1;
            w_nx_bx         = bus.draw_x;
            w_nx_by         = bus.draw_y;
            w_nx_bcol       = bus.draw_colour;
            w_nx_cnt        = '0;
            w_nx_from_erase = 1'b0;
            w_nx_state      = S_DRAW;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_bcol       <= '0;
            r_from_erase <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_col        <= '0;
            r_wren       <= 1'b0;
            r_eack       <= 1'b0;
            r_dack       <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef CELL_DRAW_CLEAR_EN
            r_cack       <= 1'b0;
`endif
        end else begin
            r_state      <= w_nx_state;
            r_cnt        <= w_nx_cnt;
            r_bx         <= w_nx_bx;
            r_by         <= w_nx_by;
            r_bcol       <= w_nx_bcol;
            r_from_erase <= w_nx_from_erase;
            r_x          <= w_nx_x;
            r_y          <= w_nx_y;
            r_col        <= w_nx_col;
            r_wren       <= w_nx_wren;
            r_eack       <= w_nx_eack;
            r_dack       <= w_nx_dack;
            r_done       <= w_nx_done;
            r_busy       <= (w_nx_state != S_IDLE);
`ifdef CELL_DRAW_CLEAR_EN
            r_cack       <= w_nx_cack;
`endif
        end
    end

    assign bus.erase_ack = r_eack;
    assign bus.draw_ack  = r_dack;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.colour    = r_col;
    assign bus.wren      = r_wren;
`ifdef CELL_DRAW_CLEAR_EN
    assign bus.clear_ack = r_cack;
`endif

endmodule
